// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy scoreboard and same-index write conflict flag.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data (and busy) to read ports.
module regfile_mp #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   parameter  int NWR   = 2,
   localparam int IDXW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*IDXW-1:0]  rd_idx,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*IDXW-1:0]  wr_idx,
   input  logic [NWR*XLEN-1:0]  wr_data,
   input  logic                 iss_en,
   input  logic [IDXW-1:0]      iss_idx,
   output logic [NREGS-1:0]     busy_vec,
   output logic                 wr_conflict
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic             wr_conflict_q;
   logic             wr_conflict_d;
   logic [NWR-1:0]   wr_act_s;
   logic             iss_act_s;

   // A write or issue only counts when it targets a nonzero register.
   always_comb begin
      wr_act_s = {NWR{1'b0}};
      for (int w = 0; w < NWR; w++) begin
         wr_act_s[w] = wr_en[w] & (wr_idx[w*IDXW +: IDXW] != {IDXW{1'b0}});
      end
      iss_act_s = iss_en & (iss_idx != {IDXW{1'b0}});
   end

   // Next-state for array and scoreboard; ascending port order lets the highest port win.
   always_comb begin
      logic wr_hit;
      logic iss_hit;
      regs_d = regs_q;
      busy_d = busy_q;
      regs_d[0] = {XLEN{1'b0}};
      busy_d[0] = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         wr_hit = 1'b0;
         for (int w = 0; w < NWR; w++) begin
            if (wr_act_s[w] && (wr_idx[w*IDXW +: IDXW] == IDXW'(r))) begin
               regs_d[r] = wr_data[w*XLEN +: XLEN];
               wr_hit    = 1'b1;
            end else begin
               regs_d[r] = regs_d[r];
            end
         end
         iss_hit = iss_act_s & (iss_idx == IDXW'(r));
         // A new producer issued alongside the completing write keeps the register busy.
         if (iss_hit) begin
            busy_d[r] = 1'b1;
         end else if (wr_hit) begin
            busy_d[r] = 1'b0;
         end else begin
            busy_d[r] = busy_q[r];
         end
      end
   end

   // Flag any pair of active write ports aiming at the same register.
   always_comb begin
      wr_conflict_d = 1'b0;
      for (int a = 0; a < NWR; a++) begin
         for (int b = a + 1; b < NWR; b++) begin
            if (wr_act_s[a] && wr_act_s[b] &&
                (wr_idx[a*IDXW +: IDXW] == wr_idx[b*IDXW +: IDXW])) begin
               wr_conflict_d = 1'b1;
            end else begin
               wr_conflict_d = wr_conflict_d;
            end
         end
      end
   end

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin
      logic [IDXW-1:0] idx;
      rd_data = {(NRD*XLEN){1'b0}};
      rd_busy = {NRD{1'b0}};
      for (int p = 0; p < NRD; p++) begin
         idx = rd_idx[p*IDXW +: IDXW];
         if (idx == {IDXW{1'b0}}) begin
            rd_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
            rd_busy[p]              = 1'b0;
         end else begin
            rd_data[p*XLEN +: XLEN] = regs_q[idx];
            rd_busy[p]              = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
               if (wr_act_s[w] && (wr_idx[w*IDXW +: IDXW] == idx)) begin
                  rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                  rd_busy[p]              = iss_act_s & (iss_idx == idx);
               end else begin
                  rd_busy[p] = rd_busy[p];
               end
            end
`else
            rd_busy[p] = rd_busy[p];
`endif
         end
      end
   end

   // State registers; reset clears the array, scoreboard and conflict pulse at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= {XLEN{1'b0}};
         end
         busy_q        <= {NREGS{1'b0}};
         wr_conflict_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         busy_q        <= busy_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign busy_vec    = busy_q;
   assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, 2 read / 2 write ports).
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int IDXW = 5;

   logic            clk;
   logic            rst_n;
   logic [9:0]      rd_idx;
   logic [63:0]     rd_data;
   logic [1:0]      rd_busy;
   logic [1:0]      wr_en;
   logic [9:0]      wr_idx;
   logic [63:0]     wr_data;
   logic            iss_en;
   logic [4:0]      iss_idx;
   logic [31:0]     busy_vec;
   logic            wr_conflict;

   int n_pass;
   int n_total;

   regfile_mp dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .iss_en      (iss_en),
      .iss_idx     (iss_idx),
      .busy_vec    (busy_vec),
      .wr_conflict (wr_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rdv(input int p);
      return rd_data[p*XLEN +: XLEN];
   endfunction

   task automatic idle();
      wr_en   = 2'b00;
      wr_idx  = 10'd0;
      wr_data = 64'd0;
      iss_en  = 1'b0;
      iss_idx = 5'd0;
   endtask

   task automatic set_wr(input int w, input logic [4:0] idx, input logic [31:0] data);
      wr_en[w]                 = 1'b1;
      wr_idx[w*IDXW +: IDXW]   = idx;
      wr_data[w*XLEN +: XLEN]  = data;
   endtask

   task automatic set_rd(input int p, input logic [4:0] idx);
      rd_idx[p*IDXW +: IDXW] = idx;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         set_rd(0, 5'(i));
         set_rd(1, 5'(31 - i));
         #1;
         n_total++;
         if (rdv(0) !== 32'd0) $display("FAIL reset_rd0 idx=%0d got=%h exp=%h", i, rdv(0), 32'd0);
         else n_pass++;
         n_total++;
         if (rdv(1) !== 32'd0) $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", 31 - i, rdv(1), 32'd0);
         else n_pass++;
      end
      n_total++;
      if (busy_vec !== 32'd0) $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'd0);
      else n_pass++;
      n_total++;
      if (wr_conflict !== 1'b0) $display("FAIL reset_conflict got=%b exp=%b", wr_conflict, 1'b0);
      else n_pass++;
   endtask

   task automatic test_write_basic();
      logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hDEADBEEF;
`else
      exp_same = 32'h0;
`endif
      @(negedge clk);
      idle();
      set_wr(0, 5'd5, 32'hDEADBEEF);
      set_wr(1, 5'd0, 32'h00001234);
      set_rd(0, 5'd5);
      set_rd(1, 5'd0);
      #1;
      n_total++;
      if (rdv(0) !== exp_same) $display("FAIL same_cycle_r5 got=%h exp=%h", rdv(0), exp_same);
      else n_pass++;
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (rdv(0) !== 32'hDEADBEEF) $display("FAIL write_r5 got=%h exp=%h", rdv(0), 32'hDEADBEEF);
      else n_pass++;
      n_total++;
      if (rdv(1) !== 32'h0) $display("FAIL write_r0 got=%h exp=%h", rdv(1), 32'h0);
      else n_pass++;
      n_total++;
      if (wr_conflict !== 1'b0) $display("FAIL no_conflict got=%b exp=%b", wr_conflict, 1'b0);
      else n_pass++;
   endtask

   task automatic test_conflict();
      @(negedge clk);
      idle();
      set_wr(0, 5'd7, 32'h00001111);
      set_wr(1, 5'd7, 32'h00002222);
      set_rd(0, 5'd7);
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (rdv(0) !== 32'h00002222) $display("FAIL conflict_data got=%h exp=%h", rdv(0), 32'h00002222);
      else n_pass++;
      n_total++;
      if (wr_conflict !== 1'b1) $display("FAIL conflict_pulse got=%b exp=%b", wr_conflict, 1'b1);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (wr_conflict !== 1'b0) $display("FAIL conflict_clear got=%b exp=%b", wr_conflict, 1'b0);
      else n_pass++;
   endtask

   task automatic test_busy();
      @(negedge clk);
      idle();
      iss_en  = 1'b1;
      iss_idx = 5'd9;
      set_rd(0, 5'd9);
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (busy_vec[9] !== 1'b1) $display("FAIL issue_busy got=%b exp=%b", busy_vec[9], 1'b1);
      else n_pass++;
      n_total++;
      if (rd_busy[0] !== 1'b1) $display("FAIL issue_rd_busy got=%b exp=%b", rd_busy[0], 1'b1);
      else n_pass++;
      @(negedge clk);
      set_wr(0, 5'd9, 32'h000000A5);
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (busy_vec[9] !== 1'b0) $display("FAIL write_clears_busy got=%b exp=%b", busy_vec[9], 1'b0);
      else n_pass++;
      n_total++;
      if (rd_busy[0] !== 1'b0) $display("FAIL write_clears_rd_busy got=%b exp=%b", rd_busy[0], 1'b0);
      else n_pass++;
      @(negedge clk);
      set_wr(1, 5'd9, 32'h000000A5);
      iss_en  = 1'b1;
      iss_idx = 5'd9;
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (busy_vec[9] !== 1'b1) $display("FAIL iss_wr_same_busy got=%b exp=%b", busy_vec[9], 1'b1);
      else n_pass++;
      n_total++;
      if (rdv(0) !== 32'h000000A5) $display("FAIL iss_wr_same_data got=%h exp=%h", rdv(0), 32'h000000A5);
      else n_pass++;
      // distinct issue and write targets in one cycle
      @(negedge clk);
      set_wr(0, 5'd11, 32'h0BADF00D);
      iss_en  = 1'b1;
      iss_idx = 5'd10;
      set_rd(0, 5'd11);
      set_rd(1, 5'd10);
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (busy_vec !== 32'h0000_0600) $display("FAIL distinct_busy got=%h exp=%h", busy_vec, 32'h0000_0600);
      else n_pass++;
      n_total++;
      if (rdv(0) !== 32'h0BADF00D) $display("FAIL distinct_data got=%h exp=%h", rdv(0), 32'h0BADF00D);
      else n_pass++;
      n_total++;
      if (rd_busy !== 2'b10) $display("FAIL distinct_rd_busy got=%b exp=%b", rd_busy, 2'b10);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      idle();
      set_wr(0, 5'd3, 32'h00000011);
      set_wr(1, 5'd3, 32'h00000055);
      iss_en  = 1'b1;
      iss_idx = 5'd3;
      set_rd(0, 5'd3);
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (rdv(0) !== 32'h00000055 || busy_vec[3] !== 1'b1 || wr_conflict !== 1'b1)
         $display("FAIL pre_reset_state got=%h/%b/%b exp=%h/%b/%b",
                  rdv(0), busy_vec[3], wr_conflict, 32'h00000055, 1'b1, 1'b1);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (rdv(0) !== 32'h0) $display("FAIL async_rst_data got=%h exp=%h", rdv(0), 32'h0);
      else n_pass++;
      n_total++;
      if (busy_vec !== 32'h0) $display("FAIL async_rst_busy got=%h exp=%h", busy_vec, 32'h0);
      else n_pass++;
      n_total++;
      if (wr_conflict !== 1'b0) $display("FAIL async_rst_conflict got=%b exp=%b", wr_conflict, 1'b0);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      set_wr(0, 5'd4, 32'h00000077);
      iss_en  = 1'b1;
      iss_idx = 5'd12;
      set_rd(1, 5'd4);
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (rdv(1) !== 32'h00000077) $display("FAIL post_reset_write got=%h exp=%h", rdv(1), 32'h00000077);
      else n_pass++;
      n_total++;
      if (busy_vec !== 32'h0000_1000) $display("FAIL post_reset_issue got=%h exp=%h", busy_vec, 32'h0000_1000);
      else n_pass++;
   endtask

   task automatic test_r0();
      @(negedge clk);
      idle();
      set_wr(0, 5'd0, 32'h000000FF);
      set_wr(1, 5'd0, 32'h000000FF);
      iss_en  = 1'b1;
      iss_idx = 5'd0;
      set_rd(0, 5'd0);
      set_rd(1, 5'd0);
      @(posedge clk); #1;
      idle();
      #1;
      n_total++;
      if (busy_vec[0] !== 1'b0) $display("FAIL r0_busy got=%b exp=%b", busy_vec[0], 1'b0);
      else n_pass++;
      n_total++;
      if (rdv(0) !== 32'h0 || rdv(1) !== 32'h0) $display("FAIL r0_data got=%h/%h exp=%h", rdv(0), rdv(1), 32'h0);
      else n_pass++;
      n_total++;
      if (rd_busy !== 2'b00) $display("FAIL r0_rd_busy got=%b exp=%b", rd_busy, 2'b00);
      else n_pass++;
      n_total++;
      if (wr_conflict !== 1'b0) $display("FAIL r0_no_conflict got=%b exp=%b", wr_conflict, 1'b0);
      else n_pass++;
   endtask

   task automatic test_hold();
      @(negedge clk);
      idle();
      set_rd(0, 5'd4);
      set_rd(1, 5'd12);
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (rdv(0) !== 32'h00000077) $display("FAIL hold_r4 got=%h exp=%h", rdv(0), 32'h00000077);
      else n_pass++;
      n_total++;
      if (rd_busy !== 2'b10) $display("FAIL hold_busy got=%b exp=%b", rd_busy, 2'b10);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      rd_idx  = 10'd0;
      idle();
      #12;
      test_reset();
      test_write_basic();
      test_conflict();
      test_busy();
      test_async_reset();
      test_r0();
      test_hold();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count (power of 2, >=2); IDXW = log2(NREGS) is derived.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rd_idx  in  NRD*IDXW  read indices, port p at bits [p*IDXW +: IDXW].
REQ-008 rd_data  out  NRD*XLEN  read data, port p at bits [p*XLEN +: XLEN].
REQ-009 rd_busy  out  NRD  per read port: addressed register has a pending producer.
REQ-010 wr_en  in  NWR  per-port write enable.
REQ-011 wr_idx  in  NWR*IDXW  write indices.
REQ-012 wr_data  in  NWR*XLEN  write data.
REQ-013 iss_en  in  1  issue strobe: mark iss_idx busy.
REQ-014 iss_idx  in  IDXW  register gaining a pending producer.
REQ-015 busy_vec  out  NREGS  registered scoreboard, bit r = register r busy.
REQ-016 wr_conflict  out  1  registered one-cycle pulse flagging a same-index multi-port write.

Function
REQ-017 Reads SHALL be combinational; rd_data[p] = registers[rd_idx[p]] (bypass per REQ-030).
REQ-018 Register 0 SHALL read as 0 on every port, ignore writes and never be busy.
REQ-019 Write port w with wr_en[w]=1 and wr_idx[w]!=0 SHALL update that register at the next rising edge.
REQ-020 When several enabled ports target the same nonzero index in one cycle, the highest-numbered port SHALL win.
REQ-021 In that case wr_conflict SHALL be 1 for exactly the following cycle; otherwise 0.
REQ-022 An enabled write to nonzero index r SHALL clear busy_vec[r] at the next edge.
REQ-023 iss_en=1 with iss_idx!=0 SHALL set busy_vec[iss_idx] at the next edge; iss_idx=0 SHALL have no effect.
REQ-024 Issue and write to the same index in one cycle: busy SHALL be set (new producer wins); data SHALL still be written.
REQ-025 rd_busy[p] SHALL equal busy_vec[rd_idx[p]] (bypass adjustment per REQ-030); rd_busy for index 0 SHALL be 0.
REQ-026 Writes and issues to distinct indices in one cycle SHALL all take effect independently.
REQ-027 Array contents SHALL be hold-stable with no enabled write.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously clear all registers, busy_vec and wr_conflict to 0, including mid-write or mid-issue.
REQ-029 On the first rising edge after rst_n deasserts, writes and issues SHALL behave normally; no edge-aligned write is lost beyond the reset cycle.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: a read whose index matches an enabled same-cycle write (nonzero) SHALL return that wr_data (highest-numbered matching port), and rd_busy for that port SHALL be 0 unless a same-cycle issue targets that index.
REQ-031 Macro REGFILE_BYPASS_EN undefined: reads SHALL return stored values only; written data is visible the cycle after the write; rd_busy follows busy_vec only.

Verification
REQ-032 Reset then read all 32 indices on both ports -> rd_data=0, busy_vec=0, wr_conflict=0.
REQ-033 Port0 writes r5=0xDEADBEEF, port1 writes r0=0x1234 -> next cycle r5=0xDEADBEEF, r0=0; without bypass same-cycle read of r5 returns 0, with bypass returns 0xDEADBEEF.
REQ-034 Both ports write r7 (0x1111 port0, 0x2222 port1) -> r7=0x2222, wr_conflict=1 for one cycle then 0.
REQ-035 Issue r9, next cycle busy_vec[9]=1 and rd_busy for r9=1; write r9=0xA5 -> busy clears next cycle; same-cycle issue+write r9 -> busy stays 1, r9=0xA5.
REQ-036 Assert rst_n low asynchronously between edges with r3=0x55 busy -> r3=0 and busy_vec=0 immediately, before the next edge.
REQ-037 Issue r0 and write r0=0xFF -> busy_vec[0]=0, r0 reads 0 on all ports.
